// File: rtl/karatsuba_mul_arbiter.sv
// karatsuba_mul_arbiter: round-robin share of one multiplier (mul_*) among NREQ requesters (req_*), tagged valid/ready responses (resp_*), watchdog error on missing completion
module karatsuba_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW = 2,
  parameter int TIMEOUT = 64,
  parameter int MIN_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [64*NREQ-1:0]   req_a,
  input  logic [64*NREQ-1:0]   req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [127:0]         resp_p,
  output logic                 resp_err,
  output logic                 mul_start,
  output logic [63:0]          mul_a,
  output logic [63:0]          mul_b,
  input  logic [127:0]         mul_p,
  input  logic                 mul_valid,
  output logic                 busy
);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WD_MIN = WW'(MIN_LAT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, nxt;
  logic [IDW-1:0] rr_ptr, win, id_q;
  logic [WW-1:0] wd;
  logic found, take, done_ok, done_to, hs;
  function automatic logic [IDW-1:0] wrap(input int v);
    return IDW'(v >= NREQ ? v - NREQ : v);
  endfunction
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_valid[wrap(int'(rr_ptr) + i)]) win = wrap(int'(rr_ptr) + i);
    found = |req_valid;
    take = state == IDLE && found;
    done_ok = state == WAIT && wd >= WD_MIN && mul_valid;
    done_to = state == WAIT && wd == WD_LAST;
    hs = state == RESP && resp_ready;
    nxt = take ? ISSUE : state == ISSUE ? WAIT : (done_ok || done_to) ? RESP : hs ? IDLE : state;
    req_ready = take ? NREQ'(1) << win : '0;
    mul_start = state == ISSUE;
    resp_valid = state == RESP;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      id_q <= '0;
      mul_a <= '0;
      mul_b <= '0;
      wd <= '0;
      resp_id <= '0;
      resp_p <= '0;
      resp_err <= 1'b0;
    end else begin
      if (take) begin
        mul_a <= req_a[64*int'(win) +: 64];
        mul_b <= req_b[64*int'(win) +: 64];
        id_q <= win;
        rr_ptr <= wrap(int'(win) + 1);
      end
      wd <= state == WAIT ? wd + 1'b1 : '0;
      if (done_ok || done_to) begin
        resp_id <= id_q;
        resp_p <= done_ok ? mul_p : '0;
        resp_err <= !done_ok;
      end
    end
  end
endmodule

// File: tb/tb_karatsuba_mul_arbiter.sv
// tb_karatsuba_mul_arbiter: scoreboard bench with a stub multiplier for karatsuba_mul_arbiter
module tb_karatsuba_mul_arbiter;
  logic clk = 1'b0, rst;
  logic [3:0] req_valid, req_ready;
  logic [255:0] req_a, req_b;
  logic resp_valid, resp_ready, resp_err, mul_start, mul_valid, busy;
  logic [1:0] resp_id;
  logic [127:0] resp_p, mul_p;
  logic [63:0] mul_a, mul_b;
  typedef struct {logic [1:0] id; logic err; logic [127:0] p;} exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0, nresp = 0, starts = 0, lat = 3;
  bit dead = 0;
  karatsuba_mul_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_p(resp_p), .resp_err(resp_err), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .mul_valid(mul_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [263:0] act, input logic [263:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic op(input int i, input logic [63:0] a, input logic [63:0] b, input logic [127:0] p, input bit err = 0);
    req_a[64*i +: 64] = a;
    req_b[64*i +: 64] = b;
    exp_q.push_back('{2'(i), err, p});
  endtask
  task automatic run_reqs(input logic [3:0] mask);
    logic [3:0] g;
    int c = 0;
    req_valid = mask;
    while (req_valid != 0 && c < 400) begin
      @(negedge clk);
      g = req_ready;
      if (g != 0) chk("grant_onehot", $countones(g), 1);
      @(posedge clk);
      #1;
      req_valid = req_valid & ~g;
      c++;
    end
    chk("grant_all", req_valid, 0);
    req_valid = 0;
  endtask
  task automatic lat_chk(input string name, input int expn);
    int n = 0;
    while (!resp_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, n, expn);
  endtask
  task automatic drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 400) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("drain", exp_q.size(), 0);
  endtask
  initial begin
    logic [127:0] prod;
    int cnt;
    bit pend;
    mul_valid = 0;
    mul_p = '0;
    prod = '0;
    cnt = 0;
    pend = 0;
    forever begin
      @(negedge clk);
      if (mul_start) begin
        starts++;
        pend = 1;
        cnt = lat + 1;
        prod = {64'b0, mul_a} * {64'b0, mul_b};
      end
      @(posedge clk);
      #1;
      mul_valid = 0;
      mul_p = {4{32'hDEADBEEF}};
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 0;
          if (!dead) begin
            mul_valid = 1;
            mul_p = prod;
          end
        end
      end
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && resp_valid && resp_ready) begin
        nresp++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected actual id=%0d p=%0h required no response", resp_id, resp_p);
        end else begin
          e = exp_q.pop_front();
          chk("resp", {resp_id, resp_err, resp_p}, {e.id, e.err, e.p});
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int s0, n0;
    rst = 1;
    req_valid = 0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_state", {busy, resp_valid, mul_start, req_ready, resp_id, resp_err}, 0);
    chk("rst_data", {mul_a, mul_b, resp_p}, 0);
    rst = 0;
    @(posedge clk);
    #1;
    op(2, 64'h3, 64'h5, 128'hF);
    s0 = starts;
    run_reqs(4'b0100);
    lat_chk("lat_single", 5);
    drain();
    chk("busy_idle", busy, 0);
    chk("start_pulses", starts - s0, 1);
    op(3, '1, '1, 128'hFFFFFFFFFFFFFFFE0000000000000001);
    run_reqs(4'b1000);
    drain();
    op(0, 64'h8000000000000000, 64'h2, 128'h1_0000000000000000);
    op(1, 64'h7, 64'h6, 128'd42);
    op(2, 64'hFFFFFFFF, 64'hFFFFFFFF, 128'hFFFFFFFE00000001);
    op(3, 64'h123456789, 64'h10, 128'h1234567890);
    run_reqs(4'b1111);
    drain();
    op(0, 64'h10, 64'h10, 128'h100);
    op(3, 64'h0, 64'h5, 128'h0);
    run_reqs(4'b1001);
    drain();
    op(1, 64'd9, 64'd9, 128'd81);
    run_reqs(4'b0010);
    drain();
    op(3, 64'd11, 64'd3, 128'd33);
    op(0, 64'd4, 64'd4, 128'd16);
    run_reqs(4'b1001);
    drain();
    resp_ready = 0;
    op(1, 64'hAAAA, 64'h3, 128'h1FFFE);
    run_reqs(4'b0010);
    op(0, 64'd100, 64'd100, 128'd10000);
    req_valid[0] = 1;
    lat_chk("lat_bp", 5);
    repeat (20) begin
      @(negedge clk);
      chk("bp_hold", {resp_valid, resp_id, resp_p, resp_err, req_ready}, {1'b1, 2'd1, 128'h1FFFE, 1'b0, 4'b0});
    end
    @(posedge clk);
    #1 resp_ready = 1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("bp_next_grant", req_ready, 4'b0001);
    @(posedge clk);
    #1 req_valid = 0;
    drain();
    dead = 1;
    op(2, 64'd6, 64'd7, 128'h0, 1);
    run_reqs(4'b0100);
    lat_chk("lat_timeout", 65);
    drain();
    dead = 0;
    op(3, 64'd6, 64'd7, 128'd42);
    run_reqs(4'b1000);
    drain();
    lat = 10;
    req_a[64 +: 64] = 64'd5;
    req_b[64 +: 64] = 64'd5;
    run_reqs(4'b0010);
    n0 = nresp;
    @(posedge clk);
    #3 rst = 1;
    #1;
    chk("rst_mid_mul", {mul_start, mul_a, mul_b}, 0);
    chk("rst_mid_resp", {resp_valid, resp_id, resp_p, resp_err}, 0);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_no_resp", nresp - n0, 0);
    chk("rst_idle", busy, 0);
    lat = 3;
    op(1, 64'd2, 64'd2, 128'd4);
    op(2, 64'd3, 64'd3, 128'd9);
    run_reqs(4'b0110);
    drain();
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
